// File: rtl/des_pkg.sv
// Shared constants for the DES S-box sequencer.
// Also holds the table pick helper used by the s_box_N modules.
package des_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int SBOX_IN_W  = 6;
    localparam int SBOX_OUT_W = 4;
    localparam int NUM_SBOX   = 8;

    // Tables are row-major, entry 0 in the top nibble; row={b5,b0}, col=b4..b1.
    function automatic logic [SBOX_OUT_W-1:0] sbox_pick(
        input logic [255:0]          tbl,
        input logic [SBOX_IN_W-1:0]  b
    );
        logic [5:0] k;
        logic [7:0] lo;
        k  = {b[5], b[0], b[4:1]};
        lo = 8'd252 - {k, 2'b00};
        return tbl[lo +: 4];
    endfunction

endpackage

// File: rtl/des_sbox_lane.sv
// One shared lookup lane: all eight S-boxes, output picked by sel.
// sel=0 selects S1, sel=7 selects S8.
module des_sbox_lane
    import des_pkg::*;
(
    input  logic [2:0]            sel,
    input  logic [SBOX_IN_W-1:0]  idx,
    output logic [SBOX_OUT_W-1:0] val
);
    logic [SBOX_OUT_W-1:0] v [NUM_SBOX];

    s_box_1 u_s1 (.idx(idx), .val(v[0]));
    s_box_2 u_s2 (.idx(idx), .val(v[1]));
    s_box_3 u_s3 (.idx(idx), .val(v[2]));
    s_box_4 u_s4 (.idx(idx), .val(v[3]));
    s_box_5 u_s5 (.idx(idx), .val(v[4]));
    s_box_6 u_s6 (.idx(idx), .val(v[5]));
    s_box_7 u_s7 (.idx(idx), .val(v[6]));
    s_box_8 u_s8 (.idx(idx), .val(v[7]));

    assign val = v[sel];
endmodule

// File: rtl/s_box_1.sv
// DES S-box 1 lookup.
module s_box_1
    import des_pkg::*;
(
    input  logic [5:0] idx,
    output logic [3:0] val
);
    localparam logic [255:0] TBL = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
    assign val = sbox_pick(TBL, idx);
endmodule

// File: rtl/s_box_2.sv
// DES S-box 2 lookup.
module s_box_2
    import des_pkg::*;
(
    input  logic [5:0] idx,
    output logic [3:0] val
);
    localparam logic [255:0] TBL = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
    assign val = sbox_pick(TBL, idx);
endmodule

// File: rtl/s_box_3.sv
// DES S-box 3 lookup.
module s_box_3
    import des_pkg::*;
(
    input  logic [5:0] idx,
    output logic [3:0] val
);
    localparam logic [255:0] TBL = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
    assign val = sbox_pick(TBL, idx);
endmodule

// File: rtl/s_box_4.sv
// DES S-box 4 lookup.
module s_box_4
    import des_pkg::*;
(
    input  logic [5:0] idx,
    output logic [3:0] val
);
    localparam logic [255:0] TBL = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
    assign val = sbox_pick(TBL, idx);
endmodule

// File: rtl/s_box_5.sv
// DES S-box 5 lookup.
module s_box_5
    import des_pkg::*;
(
    input  logic [5:0] idx,
    output logic [3:0] val
);
    localparam logic [255:0] TBL = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
    assign val = sbox_pick(TBL, idx);
endmodule

// File: rtl/s_box_6.sv
// DES S-box 6 lookup.
module s_box_6
    import des_pkg::*;
(
    input  logic [5:0] idx,
    output logic [3:0] val
);
    localparam logic [255:0] TBL = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
    assign val = sbox_pick(TBL, idx);
endmodule

// File: rtl/s_box_7.sv
// DES S-box 7 lookup.
module s_box_7
    import des_pkg::*;
(
    input  logic [5:0] idx,
    output logic [3:0] val
);
    localparam logic [255:0] TBL = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
    assign val = sbox_pick(TBL, idx);
endmodule

// File: rtl/s_box_8.sv
// DES S-box 8 lookup.
module s_box_8
    import des_pkg::*;
(
    input  logic [5:0] idx,
    output logic [3:0] val
);
    localparam logic [255:0] TBL = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;
    assign val = sbox_pick(TBL, idx);
endmodule

// File: rtl/des_sbox_sequencer.sv
// Time-multiplexed DES S-box stage: eight lookups through
// SBOX_PER_CYCLE shared lanes, valid/ready on both sides.
module des_sbox_sequencer
    import des_pkg::*;
#(
    parameter int SBOX_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);
    localparam int NUM_STEPS = NUM_SBOX / SBOX_PER_CYCLE;
    localparam int SW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam logic [SW-1:0] LAST = SW'(NUM_STEPS - 1);

    generate
        if (SBOX_PER_CYCLE != 1 && SBOX_PER_CYCLE != 2 &&
            SBOX_PER_CYCLE != 4 && SBOX_PER_CYCLE != 8) begin : g_bad_p
            $error("SBOX_PER_CYCLE must be 1, 2, 4 or 8");
        end
    endgenerate

    logic [1:0]            state;
    logic [1:0]            nstate;
    logic [SW-1:0]         step;
    logic [47:0]           hold;
    logic [31:0]           res;
    logic [2:0]            lsel [SBOX_PER_CYCLE];
    logic [SBOX_IN_W-1:0]  lidx [SBOX_PER_CYCLE];
    logic [SBOX_OUT_W-1:0] lval [SBOX_PER_CYCLE];

    // Lane j serves S-box step*P+j; S1 chunk sits in the top bits.
    for (genvar j = 0; j < SBOX_PER_CYCLE; j++) begin : g_lane
        assign lsel[j] = 3'(32'(step) * SBOX_PER_CYCLE + j);
        assign lidx[j] = 6'(hold >> (6'd42 - 6'd6 * {3'd0, lsel[j]}));
        des_sbox_lane u_lane (
            .sel (lsel[j]),
            .idx (lidx[j]),
            .val (lval[j])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= nstate;
    end

    always_comb begin
        nstate = state;
        unique case (state)
            ST_IDLE: if (in_valid)     nstate = ST_RUN;
            ST_RUN:  if (step == LAST) nstate = ST_DONE;
            ST_DONE: if (out_ready)    nstate = ST_IDLE;
            default:                   nstate = ST_IDLE;
        endcase
        if (flush) nstate = ST_IDLE;
    end

    always_comb begin
        in_ready  = (state == ST_IDLE) && !rst;
        out_valid = (state == ST_DONE);
        busy      = (state == ST_RUN) || (state == ST_DONE);
        out_data  = res;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step <= '0;
            hold <= '0;
            res  <= '0;
        end else if (flush) begin
            step <= '0;
        end else if (state == ST_IDLE && in_valid) begin
            hold <= in_data;
            step <= '0;
        end else if (state == ST_RUN) begin
            for (int j = 0; j < SBOX_PER_CYCLE; j++)
                res[(5'd28 - {lsel[j], 2'b00}) +: 4] <= lval[j];
            step <= (step == LAST) ? '0 : step + 1'b1;
        end
    end
endmodule

// File: tb/tb_des_sbox_sequencer.sv
// Bench for des_sbox_sequencer: three instances (P=1, 8, 2) checked
// against a decimal-table DES S-box model through a scoreboard queue.
module tb_des_sbox_sequencer;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        out_ready;
    logic [47:0] din;
    logic        iv [3];
    logic        ir [3];
    logic        ov [3];
    logic        bz [3];
    logic [31:0] od [3];

    int compared;
    int mismatched;
    int cyc;
    int acc_cyc;
    logic [31:0] sbq [$];

    localparam int STEPS [3] = '{8, 1, 4};

    des_sbox_sequencer #(.SBOX_PER_CYCLE(1)) u_p1 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_data(din), .flush(flush), .out_valid(ov[0]),
        .out_ready(out_ready), .out_data(od[0]), .busy(bz[0])
    );
    des_sbox_sequencer #(.SBOX_PER_CYCLE(8)) u_p8 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_data(din), .flush(flush), .out_valid(ov[1]),
        .out_ready(out_ready), .out_data(od[1]), .busy(bz[1])
    );
    des_sbox_sequencer #(.SBOX_PER_CYCLE(2)) u_p2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_data(din), .flush(flush), .out_valid(ov[2]),
        .out_ready(out_ready), .out_data(od[2]), .busy(bz[2])
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    int sb [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,
          0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,
          15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,
          3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,
          13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,
          13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,
          1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,
          13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,
          3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,
          14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,
          11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,
          10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,
          4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,
          13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,
          6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,
          1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,
          2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };

    function automatic logic [31:0] ref_f(input logic [47:0] d);
        logic [31:0] r;
        logic [5:0]  c;
        int          row;
        int          col;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            c   = d[47 - 6*i -: 6];
            row = {c[5], c[0]};
            col = c[4:1];
            r[31 - 4*i -: 4] = 4'(sb[i][row*16 + col]);
        end
        return r;
    endfunction

    function automatic logic [47:0] rnd48();
        return {16'($urandom), 32'($urandom)};
    endfunction

    task automatic send(input int sel, input logic [47:0] d, input bit push);
        int n;
        n = 0;
        while (ir[sel] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            compared++;
            mismatched++;
            $display("FAIL send_wait dut%0d: in_ready never rose", sel);
        end
        iv[sel] = 1'b1;
        din     = d;
        @(posedge clk);
        acc_cyc = cyc;
        if (push) sbq.push_back(ref_f(d));
        @(negedge clk);
        iv[sel] = 1'b0;
        din     = rnd48();
    endtask

    task automatic expect_out(input int sel, output logic [31:0] got);
        int n;
        logic [31:0] e;
        n = 0;
        while (ov[sel] !== 1'b1 && n < 50) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        got = od[sel];
        compared++;
        if (n !== STEPS[sel]) begin
            mismatched++;
            $display("FAIL latency dut%0d: got %0d want %0d", sel, n, STEPS[sel]);
        end
        e = (sbq.size() > 0) ? sbq.pop_front() : 32'hxxxxxxxx;
        compared++;
        if (od[sel] !== e) begin
            mismatched++;
            $display("FAIL data dut%0d: got %h want %h", sel, od[sel], e);
        end
        @(posedge clk);
        @(negedge clk);
        compared++;
        if (ov[sel] !== 1'b0 || ir[sel] !== 1'b1) begin
            mismatched++;
            $display("FAIL handoff dut%0d: out_valid=%b in_ready=%b want 0/1",
                     sel, ov[sel], ir[sel]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b1;
        din = '0;
        for (int i = 0; i < 3; i++) iv[i] = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            compared++;
            if (ir[i] !== 1'b0) begin
                mismatched++;
                $display("FAIL rst_in_ready dut%0d: got %b want 0", i, ir[i]);
            end
        end
        rst = 1'b0;
        #1;
        compared++;
        if (ir[0] !== 1'b1 || ov[0] !== 1'b0 || bz[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_ctl: ready=%b valid=%b busy=%b want 1/0/0",
                     ir[0], ov[0], bz[0]);
        end
        compared++;
        if (od[0] !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_data: got %h want 00000000", od[0]);
        end
    endtask

    task automatic test_zero_p1();
        logic [31:0] got;
        send(0, 48'h0, 1);
        expect_out(0, got);
        compared++;
        if (got !== 32'hEFA72C4D) begin
            mismatched++;
            $display("FAIL zero_p1: got %h want EFA72C4D", got);
        end
    endtask

    task automatic test_ones_p8();
        logic [31:0] got;
        send(1, 48'hFFFF_FFFF_FFFF, 1);
        expect_out(1, got);
        compared++;
        if (got !== 32'hD9CE3DCB) begin
            mismatched++;
            $display("FAIL ones_p8: got %h want D9CE3DCB", got);
        end
    endtask

    task automatic test_random();
        logic [31:0] got;
        for (int s = 0; s < 3; s++)
            for (int k = 0; k < 4; k++) begin
                send(s, rnd48(), 1);
                expect_out(s, got);
            end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got;
        int t0;
        send(0, rnd48(), 1);
        t0 = acc_cyc;
        expect_out(0, got);
        send(0, rnd48(), 1);
        compared++;
        if (acc_cyc - t0 !== 10) begin
            mismatched++;
            $display("FAIL throughput: got %0d cycles want 10", acc_cyc - t0);
        end
        expect_out(0, got);
    endtask

    task automatic test_backpressure();
        logic [31:0] first;
        logic [31:0] e;
        int n;
        int bad;
        out_ready = 1'b0;
        send(0, rnd48(), 1);
        n = 0;
        while (ov[0] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        first = od[0];
        e = (sbq.size() > 0) ? sbq.pop_front() : 32'hxxxxxxxx;
        compared++;
        if (first !== e) begin
            mismatched++;
            $display("FAIL bp_data: got %h want %h", first, e);
        end
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (ov[0] !== 1'b1 || od[0] !== e || ir[0] !== 1'b0) bad++;
        end
        compared++;
        if (bad !== 0) begin
            mismatched++;
            $display("FAIL bp_hold: %0d unstable cycles want 0", bad);
        end
        out_ready = 1'b1;
        @(negedge clk);
        compared++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
            mismatched++;
            $display("FAIL bp_release: valid=%b ready=%b want 0/1", ov[0], ir[0]);
        end
    endtask

    task automatic test_flush();
        logic [31:0] got;
        int seen;
        send(0, 48'h0, 0);
        repeat (3) @(negedge clk);
        flush = 1'b1;
        iv[0] = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        iv[0] = 1'b0;
        #1;
        compared++;
        if (ir[0] !== 1'b1 || bz[0] !== 1'b0 || ov[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL flush_run: ready=%b busy=%b valid=%b want 1/0/0",
                     ir[0], bz[0], ov[0]);
        end
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (ov[0] !== 1'b0) seen++;
        end
        compared++;
        if (seen !== 0) begin
            mismatched++;
            $display("FAIL flush_novalid: %0d valid cycles want 0", seen);
        end
        flush = 1'b1;
        iv[0] = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        iv[0] = 1'b0;
        #1;
        compared++;
        if (bz[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL flush_idle: busy=%b want 0", bz[0]);
        end
        send(0, 48'h0, 1);
        expect_out(0, got);
        compared++;
        if (got !== 32'hEFA72C4D) begin
            mismatched++;
            $display("FAIL flush_next: got %h want EFA72C4D", got);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] got;
        send(2, rnd48(), 0);
        repeat (2) @(negedge clk);
        compared++;
        if (bz[2] !== 1'b1) begin
            mismatched++;
            $display("FAIL arst_pre: busy=%b want 1", bz[2]);
        end
        #2 rst = 1'b1;
        #1;
        compared++;
        if (bz[2] !== 1'b0 || ov[2] !== 1'b0 || ir[2] !== 1'b0 || od[2] !== 32'h0) begin
            mismatched++;
            $display("FAIL arst_now: busy=%b valid=%b ready=%b data=%h want 0/0/0/0",
                     bz[2], ov[2], ir[2], od[2]);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        compared++;
        if (ir[2] !== 1'b1 || bz[2] !== 1'b0) begin
            mismatched++;
            $display("FAIL arst_after: ready=%b busy=%b want 1/0", ir[2], bz[2]);
        end
        send(2, 48'h0, 1);
        expect_out(2, got);
        compared++;
        if (got !== 32'hEFA72C4D) begin
            mismatched++;
            $display("FAIL arst_next: got %h want EFA72C4D", got);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        cyc        = 0;
        acc_cyc    = 0;
        test_reset();
        test_zero_p1();
        test_ones_p8();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/des_sbox_sequencer.md
Name: des_sbox_sequencer

Overview:
Time-multiplexed S-box substitution engine for the DES round function. Accepts the 48-bit key-mixed expansion value (E(R) xor K) over a valid/ready handshake. Sequences the eight S-box lookups through SBOX_PER_CYCLE shared lookup lanes and returns the 32-bit pre-P-permutation result over a second valid/ready handshake. Sits between the key-mix XOR and the P permutation in the round datapath, trading latency for area.

Parameters:
SBOX_PER_CYCLE, 1, S-box lookups performed per cycle; legal values 1, 2, 4, 8; any other value is a elaboration error.
NUM_STEPS, 8/SBOX_PER_CYCLE, derived (localparam), RUN cycles per block.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream has a 48-bit word
in_ready  output  1  block can accept a word (IDLE only)
in_data  input  48  key-mixed value; bits [47:42] feed S1, ..., bits [5:0] feed S8
flush  input  1  synchronous abort; returns to IDLE, discards work
out_valid  output  1  out_data holds a complete result
out_ready  input  1  downstream accepts result
out_data  output  32  {S1,S2,...,S8}; S1 nibble in [31:28], S8 in [3:0]
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async, rst=1): state=IDLE, step=0, in_ready=0 while rst held, then 1 in IDLE. out_valid=0, out_data=32'h0, busy=0, input holding register=0.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. If in_valid, on the edge: latch in_data, step<=0, state<=RUN.
- RUN: in_ready=0. Each cycle lane j (0..SBOX_PER_CYCLE-1) looks up S-box number step*SBOX_PER_CYCLE+j+1 on its 6-bit chunk. It writes the 4-bit result into the matching out_data nibble on the edge. step increments each cycle. When step==NUM_STEPS-1, state<=DONE after the write.
- S-box index convention per chunk: row={b5,b0}, column=b4..b1, as in the existing s_box_N modules.
- DONE: out_valid=1, out_data stable. On out_valid&out_ready: state<=IDLE, out_valid<=0. There is no same-cycle re-accept: in_ready rises the cycle after handoff.
- Latency: accept edge T. The result is visible (out_valid=1) after edge T+NUM_STEPS. For SBOX_PER_CYCLE=1 this is 8 cycles; for 8 it is 1 cycle. Throughput is one block per NUM_STEPS+2 cycles with out_ready held high.
- out_data holds its last value in IDLE until overwritten nibble-by-nibble in the next RUN. Consumers use it only when out_valid=1.
- flush: highest priority after rst. In any state, on the edge: state<=IDLE, out_valid<=0, step<=0. A simultaneous in_valid is ignored that cycle. A simultaneous out_ready in DONE does not count as a handoff.
- rst mid-RUN or in DONE: immediate return to reset values. The partial result is lost.
- in_data changes after acceptance have no effect, because the value is latched.
- Backpressure: DONE is held indefinitely while out_ready=0.

Decomposition:
- Shared package des_pkg:
  - state encoding constants (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2);
  - chunk width constant SBOX_IN_W=6;
  - SBOX_OUT_W=4;
  - NUM_SBOX=8.
- Sub-module des_sbox_lane: 3-bit sbox select plus 6-bit index in, 4-bit value out. Purely combinational. It instantiates s_box_1..s_box_8 and muxes their outputs by select. The sequencer instantiates SBOX_PER_CYCLE lanes via generate.

Test Plan:
- Reset then idle, P=1: rst pulse → in_ready=1, out_valid=0, busy=0, out_data=32'h0.
- Zero vector, P=1: in_data=48'h0 accepted at T → out_valid rises after edge T+8, out_data=32'hEFA72C4D.
- All-ones vector, P=8: in_data=48'hFFFFFFFFFFFF → out_valid after edge T+1, out_data=32'hD9CE3DCB.
- Backpressure: hold out_ready=0 for 20 cycles in DONE → out_valid and out_data stable, in_ready=0. Release → handoff, in_ready=1 the next cycle.
- Flush mid-RUN, P=1: flush at step 3 with in_valid=1 → IDLE next cycle, no out_valid. The next 48'h0 block still yields 32'hEFA72C4D.
- Async reset mid-RUN, P=2: assert rst between edges at step 2 → outputs reach reset values without waiting for a clock edge, and the FSM is in IDLE after release.
